// File: rtl/seq_detect_prog_shift_reg_pkg.sv
// Shared constants, configuration record and helpers for the programmable sequence detector.
package seq_detect_pkg;

    localparam int unsigned MAX_LEN_DEFAULT = 16;
    localparam int unsigned CNT_W_DEFAULT   = 8;
    localparam int unsigned LEN_W_DEFAULT   = $clog2(MAX_LEN_DEFAULT + 1);

    // Live pattern configuration, held between cfg_we pulses.
    typedef struct packed {
        logic [MAX_LEN_DEFAULT-1:0] pattern;
        logic [MAX_LEN_DEFAULT-1:0] mask;
        logic [LEN_W_DEFAULT-1:0]   len;
        logic                       overlap;
    } cfg_t;

    localparam cfg_t CFG_RESET = '{
        pattern: '0,
        mask:    '1,
        len:     '0,
        overlap: 1'b1
    };

    // Low len bits set; positions at or above len never take part in a compare.
    function automatic logic [MAX_LEN_DEFAULT-1:0] len_to_mask(input logic [LEN_W_DEFAULT-1:0] len);
        logic [MAX_LEN_DEFAULT-1:0] m;
        m = '0;
        for (int i = 0; i < int'(MAX_LEN_DEFAULT); i++) begin
            m[i] = (LEN_W_DEFAULT'(i) < len);
        end
        return m;
    endfunction

endpackage

// File: rtl/seq_detect_prog_shift_reg_if.sv
// Bit-stream, configuration and result signals of the sequence detector.
interface seq_detect_prog_shift_reg_if
    import seq_detect_pkg::*;
#(
    parameter int unsigned MAX_LEN = MAX_LEN_DEFAULT,
    parameter int unsigned CNT_W   = CNT_W_DEFAULT
);
    localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);

    logic               in_valid;
    logic               new_bit;
    logic               cfg_we;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [MAX_LEN-1:0] cfg_mask;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic               cnt_clr;
    logic               detected;
    logic [CNT_W-1:0]   match_count;
    logic               count_sat;

    // Controller / stream source side.
    modport master (
        output in_valid, new_bit, cfg_we, cfg_pattern, cfg_mask, cfg_len, cfg_overlap, cnt_clr,
        input  detected, match_count, count_sat
    );

    // Detector side.
    modport slave (
        input  in_valid, new_bit, cfg_we, cfg_pattern, cfg_mask, cfg_len, cfg_overlap, cnt_clr,
        output detected, match_count, count_sat
    );

endinterface

// File: rtl/seq_detect_prog_shift_reg_sat_counter.sv
// Saturating up-counter with clear-over-increment priority and a registered full flag.
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count,
    output logic         sat
);

    logic [W-1:0] count_next;

    // Next count: clear wins, otherwise increment until all ones.
    always_comb begin
        count_next = count;
        if (clr) begin
            count_next = '0;
        end else if (inc && (count != '1)) begin
            count_next = count + W'(1);
        end
    end

    // Count and full flag update together so sat always describes count.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            sat   <= 1'b0;
        end else begin
            count <= count_next;
            sat   <= (count_next == '1);
        end
    end

endmodule

// File: rtl/seq_detect_prog_shift_reg.sv
// Run-time programmable serial sequence detector with don't-care mask,
// optional overlap, valid qualifier and saturating match counter.
// MAX_LEN must not exceed MAX_LEN_DEFAULT (the stored configuration record width).
module seq_detect_prog_shift_reg
    import seq_detect_pkg::*;
#(
    parameter int unsigned MAX_LEN = MAX_LEN_DEFAULT,
    parameter int unsigned CNT_W   = CNT_W_DEFAULT
) (
    input logic                   clk,
    input logic                   rst,
    seq_detect_prog_shift_reg_if.slave bus
);

    localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);

    // The oldest of MAX_LEN history bits is shifted out before it can join a
    // window, so only MAX_LEN-1 bits are stored; the window adds new_bit.
    logic [MAX_LEN-2:0] shift_q;
    logic [MAX_LEN-1:0] window;
    logic [LEN_W-1:0]   fill_q;
    logic [LEN_W-1:0]   fill_next;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   load_len;
    logic [MAX_LEN-1:0] len_mask;
    logic [MAX_LEN-1:0] pat_q;
    logic [MAX_LEN-1:0] msk_q;
    cfg_t               cfg_q;
    cfg_t               cfg_load;
    logic               accept;
    logic               hit;
    logic               detected_q;

    // Build the configuration record to capture on cfg_we, clamping the length.
    always_comb begin
        load_len          = (bus.cfg_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : bus.cfg_len;
        cfg_load          = CFG_RESET;
        cfg_load.pattern  = MAX_LEN_DEFAULT'(bus.cfg_pattern);
        cfg_load.mask     = MAX_LEN_DEFAULT'(bus.cfg_mask);
        cfg_load.len      = LEN_W_DEFAULT'(load_len);
        cfg_load.overlap  = bus.cfg_overlap;
    end

    // Match evaluation on the post-shift window of an accepted bit.
    always_comb begin
        accept    = bus.in_valid & ~bus.cfg_we;
        window    = {shift_q, bus.new_bit};
        fill_next = (fill_q == LEN_W'(MAX_LEN)) ? fill_q : fill_q + LEN_W'(1);
        len_q     = LEN_W'(cfg_q.len);
        pat_q     = MAX_LEN'(cfg_q.pattern);
        msk_q     = MAX_LEN'(cfg_q.mask);
        len_mask  = MAX_LEN'(len_to_mask(cfg_q.len));
        hit       = accept
                    && (len_q != '0)
                    && (fill_next >= len_q)
                    && (((window ^ pat_q) & msk_q & len_mask) == '0);
    end

    // History, fill level, configuration and match pulse; cfg_we overrides the stream.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q    <= '0;
            fill_q     <= '0;
            cfg_q      <= CFG_RESET;
            detected_q <= 1'b0;
        end else if (bus.cfg_we) begin
            shift_q    <= '0;
            fill_q     <= '0;
            cfg_q      <= cfg_load;
            detected_q <= 1'b0;
        end else begin
            detected_q <= hit;
            if (accept) begin
                shift_q <= window[MAX_LEN-2:0];
                fill_q  <= (hit && !cfg_q.overlap) ? '0 : fill_next;
            end
        end
    end

    assign bus.detected = detected_q;

    sat_counter #(
        .W (CNT_W)
    ) u_match_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (hit),
        .clr   (bus.cnt_clr | bus.cfg_we),
        .count (bus.match_count),
        .sat   (bus.count_sat)
    );

endmodule

// File: tb/tb_seq_detect_prog_shift_reg.sv
// Scoreboard bench for seq_detect_prog_shift_reg: a history-based reference model
// pushes expected results per driven cycle; they are popped and compared after the edge.
module tb_seq_detect_prog_shift_reg;
    import seq_detect_pkg::*;

    localparam int unsigned ML  = 16;
    localparam int unsigned CW  = 8;
    localparam int unsigned CW2 = 2;
    localparam int unsigned LW  = $clog2(ML + 1);

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    seq_detect_prog_shift_reg_if #(.MAX_LEN(ML), .CNT_W(CW))  bus ();
    seq_detect_prog_shift_reg_if #(.MAX_LEN(ML), .CNT_W(CW2)) bus2 ();

    seq_detect_prog_shift_reg #(.MAX_LEN(ML), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    seq_detect_prog_shift_reg #(.MAX_LEN(ML), .CNT_W(CW2)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2.slave)
    );

    typedef struct {
        bit det;
        int cnt;
        int cnt2;
    } exp_t;

    exp_t          sb[$];
    bit            hist[$];
    logic [ML-1:0] m_pat;
    logic [ML-1:0] m_mask;
    int            m_len;
    bit            m_ovl;
    int            m_cnt;
    int            m_cnt2;
    int            n_checks = 0;
    int            n_fail   = 0;
    int            pulses   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock of stimulus: update the model, push expectation, then compare after the edge.
    task automatic drive(input bit r, input bit we, input bit v, input bit b, input bit clr,
                         input logic [ML-1:0] pat, input logic [ML-1:0] msk,
                         input logic [LW-1:0] len, input bit ovl);
        exp_t e;
        bit   hit;
        rst              = r;
        bus.cfg_we       = we;   bus2.cfg_we       = we;
        bus.in_valid     = v;    bus2.in_valid     = v;
        bus.new_bit      = b;    bus2.new_bit      = b;
        bus.cnt_clr      = clr;  bus2.cnt_clr      = clr;
        bus.cfg_pattern  = pat;  bus2.cfg_pattern  = pat;
        bus.cfg_mask     = msk;  bus2.cfg_mask     = msk;
        bus.cfg_len      = len;  bus2.cfg_len      = len;
        bus.cfg_overlap  = ovl;  bus2.cfg_overlap  = ovl;

        hit = 1'b0;
        if (r) begin
            m_pat = '0; m_mask = '1; m_len = 0; m_ovl = 1'b1;
            hist.delete(); m_cnt = 0; m_cnt2 = 0;
        end else if (we) begin
            m_pat = pat; m_mask = msk; m_ovl = ovl;
            m_len = (int'(len) > int'(ML)) ? int'(ML) : int'(len);
            hist.delete(); m_cnt = 0; m_cnt2 = 0;
        end else begin
            if (v) begin
                hist.push_back(b);
                if (hist.size() > int'(ML)) void'(hist.pop_front());
                if (m_len != 0 && hist.size() >= m_len) begin
                    hit = 1'b1;
                    for (int i = 0; i < m_len; i++) begin
                        if (m_mask[i] && (hist[hist.size() - 1 - i] != m_pat[i])) hit = 1'b0;
                    end
                end
                if (hit && !m_ovl) hist.delete();
            end
            if (clr) begin
                m_cnt = 0; m_cnt2 = 0;
            end else if (hit) begin
                if (m_cnt < 255) m_cnt++;
                if (m_cnt2 < 3) m_cnt2++;
            end
        end
        e.det = hit; e.cnt = m_cnt; e.cnt2 = m_cnt2;
        sb.push_back(e);

        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("detected",  32'(bus.detected),     32'(e.det));
        check("count",     32'(bus.match_count),  e.cnt);
        check("count_sat", 32'(bus.count_sat),    32'(e.cnt == 255));
        check("detected2", 32'(bus2.detected),    32'(e.det));
        check("count2",    32'(bus2.match_count), e.cnt2);
        check("count_sat2", 32'(bus2.count_sat),  32'(e.cnt2 == 3));
        if (bus.detected === 1'b1) pulses++;
    endtask

    // Stream bit with random junk on the cfg inputs, which must be ignored.
    task automatic bit_in(input bit v, input bit b, input bit clr);
        drive(1'b0, 1'b0, v, b, clr, ML'($urandom), ML'($urandom), LW'($urandom), 1'($urandom));
    endtask

    task automatic cfg(input logic [ML-1:0] pat, input logic [ML-1:0] msk,
                       input logic [LW-1:0] len, input bit ovl, input bit v, input bit b);
        drive(1'b0, 1'b1, v, b, 1'b0, pat, msk, len, ovl);
    endtask

    task automatic do_rst();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0);
    endtask

    // Send n bits of v oldest first (v[n-1] first), with 'gap' idle cycles after each.
    task automatic send(input logic [31:0] v, input int n, input int gap);
        for (int i = n - 1; i >= 0; i--) begin
            bit_in(1'b1, v[i], 1'b0);
            for (int g = 0; g < gap; g++) bit_in(1'b0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset and default config (len 0) never detects.
        do_rst();
        do_rst();
        pulses = 0;
        send(32'b1100_1101, 8, 0);
        check("default_no_detect", 32'(pulses), 0);

        // 110011 found in 0110011.
        cfg(ML'(6'b110011), '1, LW'(6), 1'b1, 1'b0, 1'b0);
        pulses = 0;
        send(32'b0110011, 7, 0);
        check("p6_pulses", 32'(pulses), 1);
        check("p6_count", 32'(bus.match_count), 1);

        // Overlapping vs non-overlapping on 1100110011.
        cfg(ML'(6'b110011), '1, LW'(6), 1'b1, 1'b0, 1'b0);
        pulses = 0;
        send(32'b1100110011, 10, 0);
        check("ovl_pulses", 32'(pulses), 2);
        check("ovl_count", 32'(bus.match_count), 2);
        cfg(ML'(6'b110011), '1, LW'(6), 1'b0, 1'b0, 1'b0);
        pulses = 0;
        send(32'b1100110011, 10, 0);
        check("novl_pulses", 32'(pulses), 1);
        check("novl_count", 32'(bus.match_count), 1);

        // Don't-care mask: 1010 and 1110 match, 0010 does not.
        cfg(ML'(4'b1010), ML'(4'b1011), LW'(4), 1'b1, 1'b0, 1'b0);
        pulses = 0; send(32'b1010, 4, 0);
        check("mask_1010", 32'(pulses), 1);
        cfg(ML'(4'b1010), ML'(4'b1011), LW'(4), 1'b1, 1'b0, 1'b0);
        pulses = 0; send(32'b1110, 4, 0);
        check("mask_1110", 32'(pulses), 1);
        cfg(ML'(4'b1010), ML'(4'b1011), LW'(4), 1'b1, 1'b0, 1'b0);
        pulses = 0; send(32'b0010, 4, 0);
        check("mask_0010", 32'(pulses), 0);

        // Idle cycles between valid bits.
        cfg(ML'(6'b110011), '1, LW'(6), 1'b1, 1'b0, 1'b0);
        pulses = 0;
        send(32'b110011, 6, 2);
        check("gap_pulses", 32'(pulses), 1);

        // Saturation on the 2-bit counter, then clear coincident with a match.
        cfg(ML'(1'b1), ML'(1'b1), LW'(1), 1'b1, 1'b0, 1'b0);
        send(32'b11111, 5, 0);
        check("sat2_count", 32'(bus2.match_count), 3);
        check("sat2_flag", 32'(bus2.count_sat), 1);
        pulses = 0;
        bit_in(1'b1, 1'b1, 1'b1);
        check("clr_hit_pulse", 32'(pulses), 1);
        check("clr_hit_count", 32'(bus.match_count), 0);

        // cfg_we mid-pattern drops the same-edge bit and restarts fill.
        cfg(ML'(6'b110011), '1, LW'(6), 1'b1, 1'b0, 1'b0);
        send(32'b110, 3, 0);
        cfg(ML'(6'b110011), '1, LW'(6), 1'b1, 1'b1, 1'b0);
        check("reload_count", 32'(bus.match_count), 0);
        pulses = 0;
        send(32'b11001, 5, 0);
        check("reload_first5", 32'(pulses), 0);
        send(32'b1, 1, 0);
        check("reload_6th", 32'(pulses), 1);

        // len 0 disables detection.
        cfg('0, '0, LW'(0), 1'b1, 1'b0, 1'b0);
        pulses = 0; send(32'hA5A5, 16, 0);
        check("len0", 32'(pulses), 0);

        // Oversize length clamps to MAX_LEN; all-don't-care mask.
        cfg('0, '0, LW'(20), 1'b1, 1'b0, 1'b0);
        pulses = 0; send(32'h1_2345, 17, 0);
        check("clamp_pulses", 32'(pulses), 2);

        // All-don't-care, non-overlap, len 3: one match every 3 bits.
        cfg('0, '0, LW'(3), 1'b0, 1'b0, 1'b0);
        pulses = 0; send(32'b101100111, 9, 0);
        check("dc_novl", 32'(pulses), 3);

        // Reset mid-stream loses the partial match and restores defaults.
        cfg(ML'(6'b110011), '1, LW'(6), 1'b1, 1'b0, 1'b0);
        send(32'b1100, 4, 0);
        do_rst();
        pulses = 0;
        send(32'b11, 2, 0);
        check("rst_mid", 32'(pulses), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_detect_prog_shift_reg.md
Name: seq_detect_prog_shift_reg

Overview:
- Run-time programmable serial bit-sequence detector, generalising the fixed-pattern shift-register detectors to any pattern of 1..MAX_LEN bits.
- Supports per-bit don't-care mask, overlapping or non-overlapping matching, an input valid qualifier and a saturating match counter.
- Sits on serial bit streams (framing/sync-word search) and is configured by a local controller.

Parameters:
- MAX_LEN, 16, maximum pattern length in bits (>= 2).
- CNT_W, 8, width of match counter.
- LEN_W, $clog2(MAX_LEN+1), width of length field (derived, not overridden).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  new_bit is sampled on this edge when high.
- new_bit  in  1  serial data bit.
- cfg_we  in  1  load configuration on this edge.
- cfg_pattern  in  MAX_LEN  pattern; bit 0 = newest bit, bit len-1 = oldest.
- cfg_mask  in  MAX_LEN  1 = compare this position, 0 = don't care.
- cfg_len  in  LEN_W  pattern length; 0 = detection disabled.
- cfg_overlap  in  1  1 = overlapping matches allowed.
- cnt_clr  in  1  synchronous clear of match counter.
- detected  out  1  one-cycle match pulse.
- match_count  out  CNT_W  number of matches, saturating.
- count_sat  out  1  match_count is all ones.

Behaviour:
- Reset values:
  - shift_reg = 0, fill = 0.
  - pattern = 0, mask = all ones, len = 0 (disabled), overlap = 1.
  - detected = 0, match_count = 0, count_sat = 0.
- Shift register (MAX_LEN bits): on accepted bit (in_valid & ~cfg_we), shift_reg <= {shift_reg[MAX_LEN-2:0], new_bit}.
- Fill counter: counts accepted bits since reset/config/last non-overlap match, saturating at MAX_LEN.
- Match condition, evaluated on an accepted edge using the post-shift window w:
  - len != 0 AND fill_next >= len AND ((w ^ pattern) & mask & lenmask) == 0.
  - lenmask = low len bits set; bits at or above len are always ignored.
- Latency: detected is registered. It is high for exactly the one cycle following the edge that sampled the completing bit, and low otherwise, including on cycles with in_valid = 0.
- Overlap = 1: fill is unaffected by a match; e.g. "1010" on stream 101010 gives 2 matches.
- Overlap = 0: on a match, fill_next = 0, so the next match needs len fresh bits; the same stream gives 1 match.
- cfg_len > MAX_LEN: clamped to MAX_LEN at load.
- cfg_we:
  - Loads all cfg fields.
  - Clears shift_reg, fill, detected and match_count.
  - A same-edge in_valid bit is discarded (cfg wins).
- Configuration is held between cfg_we pulses; cfg inputs are ignored otherwise.
- match_count: +1 on each edge that sets detected; holds at 2^CNT_W-1; count_sat = (match_count == all ones), registered alongside the count.
- cnt_clr: clears match_count/count_sat. If a match occurs on the same edge, clear wins (count = 0); detected still pulses.
- rst mid-stream: all state returns to reset values on that edge; partial matches are lost.
- All mask bits zero with len = L: matches every accepted bit once fill >= L (overlap) or every L bits (non-overlap).

Decomposition:
- Package seq_detect_pkg:
  - MAX_LEN_DEFAULT and CNT_W_DEFAULT constants.
  - typedef struct packed cfg_t {pattern, mask, len, overlap}.
  - Function len_to_mask(len) returning lenmask.
- Sub-module sat_counter (parameter W; inputs inc, clr; outputs count, sat) instantiated for match_count.

Test Plan:
- After rst, cfg len=6, pattern=6'b110011, mask=all ones, overlap=1; stream 0,1,1,0,0,1,1 -> detected high one cycle after the 7th bit, match_count=1.
- Same cfg, stream 110011 0011 -> two detected pulses (second after bit 10), count=2; with overlap=0 the same stream -> one pulse, count=1.
- len=4, pattern=4'b1010, mask=4'b1011; streams 1010 and 1110 each -> detected; 0010 -> no detect.
- in_valid toggled low between bits of 110011 -> still exactly one pulse, one cycle after the final valid bit; no pulse during idle cycles.
- CNT_W=2, 5 matches -> count 1,2,3,3,3, count_sat high from the 3rd match; cnt_clr coincident with a match -> count 0, detected pulses.
- cfg_we with in_valid=1 mid-pattern -> bit dropped, fill=0, count=0; first 5 bits after reload never detect for len=6; len=0 -> never detects.
